// File: rtl/decode_pkg.sv
// Instruction word layout, category codes and assembler state shared by the
// fetch stage and the register-file side.
package decode_pkg;
   localparam int DATA_W  = 16;
   localparam int RADDR_W = 3;
   localparam int CAT_W   = 2;
   localparam int FUNC_W  = 4;

   localparam int CAT_MSB  = 15;
   localparam int CAT_LSB  = 14;
   localparam int FUNC_MSB = 13;
   localparam int FUNC_LSB = 10;
   localparam int DST_MSB  = 9;
   localparam int DST_LSB  = 7;
   localparam int SRC_MSB  = 6;
   localparam int SRC_LSB  = 4;

   localparam logic [CAT_W-1:0] CAT_REG = 2'b00;
   localparam logic [CAT_W-1:0] CAT_IMM = 2'b10;

   typedef enum logic {S_OP, S_IMM} state_t;

   typedef struct packed {
      logic [CAT_W-1:0]   cat;
      logic [FUNC_W-1:0]  func;
      logic [RADDR_W-1:0] dst;
      logic [RADDR_W-1:0] src;
   } opcode_t;

   function automatic opcode_t decode(input logic [DATA_W-1:0] word);
      opcode_t op;
      op.cat  = word[CAT_MSB:CAT_LSB];
      op.func = word[FUNC_MSB:FUNC_LSB];
      op.dst  = word[DST_MSB:DST_LSB];
      op.src  = word[SRC_MSB:SRC_LSB];
      return op;
   endfunction
endpackage

// File: rtl/pc_counter.sv
// Program counter: async active-low reset, load has priority over increment,
// increment wraps modulo 2^PC_W.
module pc_counter #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [PC_W-1:0] load_addr,
   input  logic            inc,
   output logic [PC_W-1:0] pc
);
   logic [PC_W-1:0] pc_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg <= RESET_PC;
      end else if (load) begin
         pc_reg <= load_addr;
      end else if (inc) begin
         pc_reg <= pc_reg + PC_W'(1);
      end
   end

   assign pc = pc_reg;
endmodule

// File: rtl/fetch_imm_assembler.sv
// Fetch-side assembler: pulls 16-bit words, joins immediate-category opcodes
// with their trailing immediate word and presents one instruction per beat.
module fetch_imm_assembler
   import decode_pkg::*;
#(
   parameter int               PC_W     = 16,
   parameter logic [PC_W-1:0]  RESET_PC = '0,
   parameter logic [CAT_W-1:0] IMM_CAT  = CAT_IMM
) (
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    fetch_addr,
   input  logic [DATA_W-1:0]  mem_word,
   input  logic               mem_valid,
   output logic               mem_ready,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    flush_addr,
   output logic               out_valid,
   output logic [PC_W-1:0]    out_pc,
   output logic [CAT_W-1:0]   category,
   output logic [FUNC_W-1:0]  func,
   output logic [RADDR_W-1:0] dst_addr,
   output logic [RADDR_W-1:0] src_addr,
   output logic [DATA_W-1:0]  immediate
);
   state_t            state_reg, state_next;
   opcode_t           pend_op_reg;
   logic [PC_W-1:0]   pend_pc_reg;
   logic              out_valid_reg, out_valid_next;
   opcode_t           out_op_reg;
   logic [DATA_W-1:0] imm_reg;
   logic [PC_W-1:0]   out_pc_reg;

   logic              hold, accept, load_pend, load_out;
   logic [PC_W-1:0]   pc;
   opcode_t           word_op;

   pc_counter #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk       (clk),
      .rst       (rst),
      .load      (flush),
      .load_addr (flush_addr),
      .inc       (accept),
      .pc        (pc)
   );

   // A presented instruction under stall freezes the whole front end.
   assign hold      = out_valid_reg && stall;
   assign mem_ready = !hold && !flush;
   assign accept    = mem_valid && mem_ready;
   assign word_op   = decode(mem_word);

   always_comb begin
      state_next     = state_reg;
      out_valid_next = out_valid_reg;
      load_pend      = 1'b0;
      load_out       = 1'b0;
      if (flush) begin
         state_next     = S_OP;
         out_valid_next = 1'b0;
      end else if (accept) begin
         case (state_reg)
            S_OP: begin
               if (word_op.cat == IMM_CAT) begin
                  state_next     = S_IMM;
                  load_pend      = 1'b1;
                  out_valid_next = 1'b0;
               end else begin
                  load_out       = 1'b1;
                  out_valid_next = 1'b1;
               end
            end
            S_IMM: begin
               state_next     = S_OP;
               load_out       = 1'b1;
               out_valid_next = 1'b1;
            end
            default: state_next = S_OP;
         endcase
      end else if (!hold) begin
         out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_OP;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= out_valid_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_op_reg <= '0;
         pend_pc_reg <= '0;
      end else if (flush) begin
         pend_op_reg <= '0;
         pend_pc_reg <= '0;
      end else if (load_pend) begin
         pend_op_reg <= word_op;
         pend_pc_reg <= pc;
      end
   end

   // In S_IMM the incoming word is the immediate; the bundle comes from pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_op_reg <= '0;
         imm_reg    <= '0;
         out_pc_reg <= '0;
      end else if (load_out) begin
         if (state_reg == S_IMM) begin
            out_op_reg <= pend_op_reg;
            imm_reg    <= mem_word;
            out_pc_reg <= pend_pc_reg;
         end else begin
            out_op_reg <= word_op;
            imm_reg    <= '0;
            out_pc_reg <= pc;
         end
      end
   end

   assign fetch_addr = pc;
   assign out_valid  = out_valid_reg;
   assign out_pc     = out_pc_reg;
   assign category   = out_op_reg.cat;
   assign func       = out_op_reg.func;
   assign dst_addr   = out_op_reg.dst;
   assign src_addr   = out_op_reg.src;
   assign immediate  = imm_reg;
endmodule

// File: tb/tb_fetch_imm_assembler.sv
// Scoreboard bench: a stream-level model predicts fetch handshakes and the
// assembled instructions; a negedge monitor pops and compares DUT outputs.
module tb_fetch_imm_assembler;
   typedef struct packed {
      logic [1:0]  cat;
      logic [3:0]  func;
      logic [2:0]  dst;
      logic [2:0]  src;
      logic [15:0] imm;
      logic [15:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fetch_addr;
   logic [15:0] mem_word;
   logic        mem_valid;
   logic        mem_ready;
   logic        stall;
   logic        flush;
   logic [15:0] flush_addr;
   logic        out_valid;
   logic [15:0] out_pc;
   logic [1:0]  category;
   logic [3:0]  func;
   logic [2:0]  dst_addr;
   logic [2:0]  src_addr;
   logic [15:0] immediate;

   int n_checks = 0;
   int n_fail   = 0;

   // Stream-level model state
   exp_t        exp_q[$];
   logic [15:0] m_pc;
   logic        m_ov;
   logic        m_pend;
   logic [15:0] m_pend_w;
   logic [15:0] m_pend_pc;

   // Monitor state
   logic held = 1'b0;
   exp_t last_seen;
   exp_t got;
   exp_t e;

   always #5 clk = ~clk;

   fetch_imm_assembler #(
      .PC_W     (16),
      .RESET_PC (16'h0000),
      .IMM_CAT  (2'b10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_addr (fetch_addr),
      .mem_word   (mem_word),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .stall      (stall),
      .flush      (flush),
      .flush_addr (flush_addr),
      .out_valid  (out_valid),
      .out_pc     (out_pc),
      .category   (category),
      .func       (func),
      .dst_addr   (dst_addr),
      .src_addr   (src_addr),
      .immediate  (immediate)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] w, input logic [15:0] imm, input logic [15:0] pc);
      exp_t r;
      r.cat  = 2'(w >> 14);
      r.func = 4'((w >> 10) & 16'hF);
      r.dst  = 3'((w >> 7) & 16'h7);
      r.src  = 3'((w >> 4) & 16'h7);
      r.imm  = imm;
      r.pc   = pc;
      return r;
   endfunction

   task automatic model_reset();
      m_pc   = 16'h0000;
      m_ov   = 1'b0;
      m_pend = 1'b0;
      m_pend_w  = 16'h0;
      m_pend_pc = 16'h0;
      exp_q.delete();
   endtask

   // One cycle: drive inputs after the edge, check handshake/PC, advance the model.
   task automatic step(input logic mv, input logic [15:0] w, input logic st,
                       input logic fl, input logic [15:0] fa);
      logic exp_ready;
      logic acc;
      @(posedge clk);
      #1;
      mem_valid = mv; mem_word = w; stall = st; flush = fl; flush_addr = fa;
      #1;
      exp_ready = !(m_ov && st) && !fl;
      acc = mv && exp_ready;
      check("fetch_addr", 64'(fetch_addr), 64'(m_pc));
      check("mem_ready", 64'(mem_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (fl) begin
         m_pc = fa; m_pend = 1'b0; m_ov = 1'b0;
      end else if (acc) begin
         if (m_pend) begin
            exp_q.push_back(mk(m_pend_w, w, m_pend_pc));
            m_pend = 1'b0; m_ov = 1'b1;
         end else if (w[15:14] == 2'b10) begin
            m_pend = 1'b1; m_pend_w = w; m_pend_pc = m_pc; m_ov = 1'b0;
         end else begin
            exp_q.push_back(mk(w, 16'h0, m_pc));
            m_ov = 1'b1;
         end
         m_pc = m_pc + 16'd1;
      end else if (!(m_ov && st)) begin
         m_ov = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         held = 1'b0;
      end else begin
         if (out_valid) begin
            got = {category, func, dst_addr, src_addr, immediate, out_pc};
            if (held) begin
               check("hold_bundle", 64'(got), 64'(last_seen));
            end else if (exp_q.size() == 0) begin
               check("unexpected_out", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("out_bundle", 64'(got), 64'(e));
               last_seen = e;
            end
         end
         held = out_valid && stall && !flush;
      end
   end

   initial begin
      logic [31:0] r;
      logic [1:0]  cat;
      logic [15:0] fa;

      rst = 1'b0; mem_valid = 1'b0; mem_word = 16'h0; stall = 1'b0;
      flush = 1'b0; flush_addr = 16'h0;
      model_reset();
      #12;
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_fetch_addr", 64'(fetch_addr), 64'h0);
      check("rst_bundle", 64'({category, func, dst_addr, src_addr, immediate, out_pc}), 64'h0);
      rst = 1'b1;

      // Register-category instruction, then immediate pair
      step(1'b1, 16'h0A30, 1'b0, 1'b0, 16'h0);
      step(1'b1, 16'h8A30, 1'b0, 1'b0, 16'h0);
      check("t1_dst", 64'(dst_addr), 64'h4);
      check("t1_src", 64'(src_addr), 64'h3);
      step(1'b1, 16'h0009, 1'b0, 1'b0, 16'h0);
      // Stall hold for three cycles over the completed immediate instruction
      step(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0);
      check("t2_imm", 64'(immediate), 64'h0009);
      check("t2_out_pc", 64'(out_pc), 64'h1);
      step(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0);
      step(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0);
      step(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0);
      // mem_valid gap while waiting for the immediate
      step(1'b1, 16'h8A30, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 16'hDEAD, 1'b0, 1'b0, 16'h0);
      step(1'b1, 16'h00FF, 1'b0, 1'b0, 16'h0);
      // Flush mid-immediate; next word must be an opcode
      step(1'b1, 16'h8A30, 1'b0, 1'b0, 16'h0);
      step(1'b1, 16'h1234, 1'b0, 1'b1, 16'h0040);
      step(1'b1, 16'h0A30, 1'b0, 1'b0, 16'h0);
      check("t5_fetch_addr", 64'(fetch_addr), 64'h0040);
      // PC wrap
      step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFF);
      step(1'b1, 16'h0A30, 1'b0, 1'b0, 16'h0);
      step(1'b1, 16'h8A30, 1'b0, 1'b0, 16'h0);
      check("t6_wrap", 64'(fetch_addr), 64'h0);
      // Async reset in the middle of an immediate instruction
      @(posedge clk);
      #1 mem_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'h0);
      check("arst_fetch_addr", 64'(fetch_addr), 64'h0);
      check("arst_bundle", 64'({category, func, dst_addr, src_addr, immediate, out_pc}), 64'h0);
      model_reset();
      #10 rst = 1'b1;
      step(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r   = $urandom;
         cat = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3));
         fa  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         step(($urandom_range(0, 3) != 0), {cat, r[13:0]},
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0), fa);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      check("drain_queue_empty", 64'(exp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_imm_assembler.md
Name: fetch_imm_assembler

Overview:
- Fetch-side assembler that sits directly upstream of the register-file read / immediate-select stage.
- Owns the PC and pulls 16-bit words from instruction memory.
- For immediate-category instructions (category 2'b10), collects the following word as the 16-bit immediate.
- Presents one complete instruction per valid beat: category, src/dst addresses, immediate, PC. These feed the immediate-vs-source selection downstream.

Parameters:
- PC_W, 16, width of PC and fetch address.
- RESET_PC, 0, PC value loaded on reset.
- IMM_CAT, 2'b10, category code whose instruction is followed by an immediate word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_addr  out  PC_W  instruction memory address (current PC).
- mem_word  in  16  instruction memory read data for fetch_addr.
- mem_valid  in  1  mem_word is valid this cycle.
- mem_ready  out  1  block accepts mem_word this cycle.
- stall  in  1  downstream cannot take a new instruction; hold outputs.
- flush  in  1  discard in-flight state and redirect PC.
- flush_addr  in  PC_W  new PC on flush.
- out_valid  out  1  output bundle holds a complete instruction.
- out_pc  out  PC_W  address of the instruction's opcode word.
- category  out  2  instruction category, word bits [15:14].
- func  out  4  function code, bits [13:10].
- dst_addr  out  3  destination register, bits [9:7].
- src_addr  out  3  source register, bits [6:4].
- immediate  out  16  immediate word; 0 for non-immediate categories.

Behaviour:

Reset (rst=0, asynchronous):
- PC = RESET_PC, state = S_OP.
- Pending registers = 0.
- All outputs = 0, out_valid = 0.

Combinational outputs:
- fetch_addr = PC.
- mem_ready = !(out_valid && stall) && !flush.
- accept = mem_valid && mem_ready.

PC:
- Increments by 1 on each accept, wrapping modulo 2^PC_W (e.g. all-ones wraps to 0).
- Unchanged when there is no accept.

State S_OP, on accept:
- If mem_word[15:14] == IMM_CAT: capture category/func/dst/src and the opcode PC into pending registers; state -> S_IMM; out_valid <= 0.
- Otherwise: load the output bundle from mem_word, immediate <= 0, out_pc <= PC, out_valid <= 1; stay in S_OP.

State S_IMM, on accept:
- Load the output bundle from the pending registers, immediate <= mem_word, out_valid <= 1.
- State -> S_OP.

No accept:
- If out_valid && stall: all outputs hold exactly.
- Otherwise: out_valid <= 0 (bubble). Bundle fields may hold stale values. State and pending registers hold.

Latency:
- Non-immediate instruction: out_valid one cycle after the accept of its word.
- Immediate instruction: out_valid one cycle after the accept of the immediate word (minimum 2 cycles from the opcode accept).

Flush (highest priority, over stall and accept):
- Next edge: PC <= flush_addr, state <= S_OP, out_valid <= 0, pending registers cleared.
- mem_word in the flush cycle is ignored.

Simultaneous events:
- stall with out_valid = 0 does not block; the block fetches and fills the empty output.
- mem_valid low in S_IMM waits indefinitely; pending fields are retained.

Reset mid-operation:
- A partially assembled immediate instruction is discarded; restart from RESET_PC.

Decomposition:
- Shared package (decode_pkg):
  - Category encodings (CAT_REG=2'b00, CAT_IMM=2'b10).
  - Field bit positions/widths (CAT_MSB=15, FUNC, DST, SRC ranges).
  - State enum {S_OP, S_IMM}.
  - Register-address width 3 and data width 16, shared with the register file.
- One natural sub-module: pc_counter (async active-low reset to RESET_PC, load on flush, increment on accept, wrap).
- The FSM and output register stay in the top.

Test Plan:
1. Reset + register-category instruction: rst low, then high with mem_valid=1, mem_word=16'h0A30 (cat 00, func 2, dst 4, src 3).
   -> Next cycle: out_valid=1, dst_addr=3'b100, src_addr=3'b011, immediate=0, out_pc=0; fetch_addr=1.
2. Immediate instruction: mem_word=16'h8A30 at PC 1, then 16'h0009 at PC 2.
   -> After the second accept: out_valid=1, category=2'b10, immediate=16'h0009, out_pc=1; no out_valid between the two accepts.
3. Stall hold: out_valid=1, stall=1 for 3 cycles, mem_valid=1.
   -> mem_ready=0, PC and outputs frozen all 3 cycles; stall=0 -> next word accepted on that edge.
4. mem_valid gap in S_IMM: opcode 16'h8A30 accepted, mem_valid=0 for 4 cycles, then 16'h00FF.
   -> out_valid=0 during the gap; then immediate=16'h00FF with the original src/dst.
5. Flush mid-immediate: opcode accepted (state S_IMM), flush=1, flush_addr=16'h0040, mem_word=16'h1234.
   -> Next cycle: fetch_addr=16'h0040, out_valid=0, state S_OP; next word decoded as an opcode, not an immediate.
6. PC wrap and async reset: PC=16'hFFFF, accept -> PC=0. Assert rst mid-cycle during S_IMM -> outputs 0 immediately (before the next edge), PC=RESET_PC.
